// File: rtl/iter_shift_if.sv
// iter_shift_if: start/done handshake and operand/result bus of the iterative shifter.
interface iter_shift_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] in;
    logic [SHW-1:0]   shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;

    modport master (output start, op, in, shamt, input busy, done, out);
    modport slave  (input start, op, in, shamt, output busy, done, out);
endinterface

// File: rtl/iter_shift_unit.sv
// iter_shift_unit: multi-cycle shifter, one bit per clock, SLL/SRL/SRA/ROR with start/done handshake.
module iter_shift_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input logic         clk,
    input logic         rst_n,
    iter_shift_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] acc_q, out_q, step_d;
    logic [SHW-1:0]   cnt_q;
    logic [1:0]       op_q;
    logic             busy_q, done_q;

    always_comb
        step_d = op_q == 2'b00 ? {acc_q[WIDTH-2:0], 1'b0} :
                 op_q == 2'b01 ? {1'b0, acc_q[WIDTH-1:1]} :
                 op_q == 2'b10 ? {acc_q[WIDTH-1], acc_q[WIDTH-1:1]} :
                                 {acc_q[0], acc_q[WIDTH-1:1]};

    // out_q is loaded on the edge entering DONE so the result is stable during the done cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    acc_q  <= bus.in;
                    cnt_q  <= bus.shamt;
                    op_q   <= bus.op;
                    busy_q <= 1'b1;
                    if (bus.shamt == '0) begin
                        state_q <= DONE;
                        out_q   <= bus.in;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q <= step_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == SHW'(1)) begin
                        state_q <= DONE;
                        out_q   <= step_d;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.out  = out_q;
endmodule

// File: tb/tb_iter_shift_unit.sv
// tb_iter_shift_unit: directed vectors with hand-computed results and latencies.
module tb_iter_shift_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    iter_shift_if #(.WIDTH(32), .SHW(5)) bus ();
    iter_shift_unit #(.WIDTH(32), .SHW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // issue a one-cycle start; returns one cycle after the start cycle
    task automatic issue(input logic [1:0] op, input logic [31:0] din, input logic [4:0] sh);
        bus.start = 1'b1;
        bus.op    = op;
        bus.in    = din;
        bus.shamt = sh;
        tick();
        bus.start = 1'b0;
    endtask

    // lat = cycles from the start cycle to the done cycle, bcnt = cycles with busy high
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 1;
        bcnt = 0;
        while (!bus.done && lat < 100) begin
            bcnt += int'(bus.busy);
            tick();
            lat++;
        end
        bcnt += int'(bus.busy);
        if (!bus.done) begin
            failures++;
            $display("FAIL timeout: no done within 100 cycles");
        end
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] din,
                       input logic [4:0] sh, input logic [31:0] exp);
        int lat, bcnt;
        issue(op, din, sh);
        wait_done(lat, bcnt);
        check({tag, "_lat"}, lat, sh + 1);
        check({tag, "_out"}, bus.out, exp);
        tick();
    endtask

    initial begin
        int lat, bcnt, dcnt;
        logic [31:0] res;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.in    = '0;
        bus.shamt = '0;
        #12;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_out", bus.out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        issue(2'b10, 32'h8000_0000, 5'd4);
        check("sra_busy", bus.busy, 1);
        wait_done(lat, bcnt);
        check("sra_lat", lat, 5);
        check("sra_out", bus.out, 32'hF800_0000);
        tick();
        check("sra_done_pulse", bus.done, 0);
        check("sra_idle", bus.busy, 0);
        check("sra_hold", bus.out, 32'hF800_0000);

        run("srl", 2'b01, 32'h8000_0000, 5'd4, 32'h0800_0000);
        run("sra_pos", 2'b10, 32'h7000_0000, 5'd4, 32'h0700_0000);

        issue(2'b00, 32'h0000_0001, 5'd31);
        wait_done(lat, bcnt);
        check("sll31_lat", lat, 32);
        check("sll31_busy", bcnt, 32);
        check("sll31_out", bus.out, 32'h8000_0000);
        tick();
        check("sll31_idle", bus.busy, 0);

        run("ror0", 2'b11, 32'h1234_5678, 5'd0, 32'h1234_5678);
        run("ror1", 2'b11, 32'h0000_0001, 5'd1, 32'h8000_0000);
        run("ror5", 2'b11, 32'h0000_00F1, 5'd5, 32'h8800_0007);

        // second start while busy must be ignored
        issue(2'b01, 32'hFFFF_FFFF, 5'd8);
        dcnt = int'(bus.done);
        tick();
        dcnt += int'(bus.done);
        issue(2'b00, 32'h0, 5'd1);
        res = '0;
        for (int i = 0; i < 14; i++) begin
            if (bus.done) begin
                dcnt++;
                res = bus.out;
                lat = i + 3;
            end
            tick();
        end
        check("ign_dones", dcnt, 1);
        check("ign_lat", lat, 9);
        check("ign_out", res, 32'h00FF_FFFF);
        check("ign_idle", bus.busy, 0);

        // start held high: shamt=1 accepts every third cycle
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.in    = 32'h0000_0001;
        bus.shamt = 5'd1;
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            dcnt += int'(bus.done);
        end
        bus.start = 1'b0;
        check("hold_dones", dcnt, 2);
        check("hold_out", bus.out, 32'h0000_0002);
        for (int i = 0; i < 4; i++) tick();
        check("hold_idle", bus.busy, 0);

        // async reset mid-operation
        issue(2'b10, 32'hF000_0000, 5'd20);
        for (int i = 0; i < 5; i++) tick();
        check("mid_busy_pre", bus.busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_out", bus.out, 0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            dcnt += int'(bus.done);
        end
        check("mid_no_done", dcnt, 0);
        run("post_sll", 2'b00, 32'h0000_0003, 5'd2, 32'h0000_000C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
